// File: rtl/csr_unit_if.sv
// Bus between the core and the machine-mode CSR unit: CSR access, trap inputs,
// read data and the redirected fetch address.
interface csr_unit_if;
   logic [31:0] pc;
   logic [31:0] write_data;
   logic [31:0] csr_address;
   logic        csr_reg_rd;
   logic        csr_reg_wr;
   logic        interupt;
   logic [31:0] data_out_to_reg;
   logic [31:0] pc_for_inst_mem;

   modport master (
      output pc, write_data, csr_address, csr_reg_rd, csr_reg_wr, interupt,
      input  data_out_to_reg, pc_for_inst_mem
   );

   modport slave (
      input  pc, write_data, csr_address, csr_reg_rd, csr_reg_wr, interupt,
      output data_out_to_reg, pc_for_inst_mem
   );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file (mstatus, mie, mtvec, mepc, mcause, mip) with a single
// external interrupt trap that redirects fetch to the mtvec-derived vector.
module csr_unit (
   input  logic       clk,
   input  logic       reset,
   csr_unit_if.slave  bus
);
   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MIP     = 12'h344;
   localparam logic [31:0] CAUSE_MEXT   = 32'h8000_000B;

   logic [31:0] mstatus_q, mstatus_d;
   logic [31:0] mie_q, mie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;

   logic [11:0] addr;
   logic [31:0] mip;
   logic [31:0] vec_base;
   logic [31:0] trap_vector;
   logic        take;
   logic        wr_en;

   assign addr     = bus.csr_address[11:0];
   assign mip      = {20'h0, bus.interupt, 11'h0};
   assign take     = bus.interupt & mstatus_q[3] & mie_q[11];
   assign wr_en    = bus.csr_reg_wr & ~take;
   assign vec_base = {mtvec_q[31:2], 2'b00};

   // Only the external interrupt is implemented, so vectored mode always lands on entry 11.
   always_comb begin
      trap_vector = vec_base;
      if (mtvec_q[1:0] == 2'b01) begin
         trap_vector = vec_base + 32'd44;
      end
   end

   assign bus.pc_for_inst_mem = take ? trap_vector : bus.pc;

   always_comb begin
      bus.data_out_to_reg = 32'h0;
      if (bus.csr_reg_rd) begin
         case (addr)
            ADDR_MSTATUS: bus.data_out_to_reg = mstatus_q;
            ADDR_MIE:     bus.data_out_to_reg = mie_q;
            ADDR_MTVEC:   bus.data_out_to_reg = mtvec_q;
            ADDR_MEPC:    bus.data_out_to_reg = mepc_q;
            ADDR_MCAUSE:  bus.data_out_to_reg = mcause_q;
            ADDR_MIP:     bus.data_out_to_reg = mip;
            default:      bus.data_out_to_reg = 32'h0;
         endcase
      end
   end

   // A taken trap owns this cycle's state update; any concurrent CSR write is dropped.
   always_comb begin
      mstatus_d = mstatus_q;
      mie_d     = mie_q;
      mtvec_d   = mtvec_q;
      mepc_d    = mepc_q;
      mcause_d  = mcause_q;
      if (take) begin
         mepc_d           = {bus.pc[31:2], 2'b00};
         mcause_d         = CAUSE_MEXT;
         mstatus_d[7]     = mstatus_q[3];
         mstatus_d[3]     = 1'b0;
         mstatus_d[12:11] = 2'b11;
      end else if (wr_en) begin
         case (addr)
            ADDR_MSTATUS: mstatus_d = bus.write_data;
            ADDR_MIE:     mie_d     = bus.write_data;
            ADDR_MTVEC:   mtvec_d   = bus.write_data;
            ADDR_MEPC:    mepc_d    = {bus.write_data[31:2], 2'b00};
            ADDR_MCAUSE:  mcause_d  = bus.write_data;
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mstatus_q <= 32'h0;
         mie_q     <= 32'h0;
         mtvec_q   <= 32'h0;
         mepc_q    <= 32'h0;
         mcause_q  <= 32'h0;
      end else begin
         mstatus_q <= mstatus_d;
         mie_q     <= mie_d;
         mtvec_q   <= mtvec_d;
         mepc_q    <= mepc_d;
         mcause_q  <= mcause_d;
      end
   end
endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: directed scenarios then random traffic, with a
// behavioural CSR model predicting read data and fetch address per cycle.
module tb_csr_unit;
   logic clk;
   logic reset;

   csr_unit_if bus_if();

   csr_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pcn;
      int          id;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn_no = 0;
   logic txn_valid = 1'b0;

   // Reference architectural state
   logic [31:0] m_status, m_ie, m_tvec, m_epc, m_cause;

   function automatic logic [31:0] model_read(input logic [11:0] a, input logic irq);
      case (a)
         12'h300: return m_status;
         12'h304: return m_ie;
         12'h305: return m_tvec;
         12'h341: return m_epc;
         12'h342: return m_cause;
         12'h344: return irq ? 32'h0000_0800 : 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] model_vector();
      logic [31:0] base;
      base = m_tvec & 32'hFFFF_FFFC;
      if (m_tvec[1:0] == 2'b01) return base + 32'd44;
      return base;
   endfunction

   task automatic cycle(input logic r, input logic [31:0] p, input logic [31:0] wd,
                        input logic [31:0] a, input logic rd, input logic wr, input logic irq);
      exp_t e;
      logic take;
      logic [11:0] a12;
      a12 = a[11:0];
      reset                  = r;
      bus_if.pc              = p;
      bus_if.write_data      = wd;
      bus_if.csr_address     = a;
      bus_if.csr_reg_rd      = rd;
      bus_if.csr_reg_wr      = wr;
      bus_if.interupt        = irq;
      take   = irq && m_status[3] && m_ie[11];
      e.data = rd ? model_read(a12, irq) : 32'h0;
      e.pcn  = take ? model_vector() : p;
      e.id   = txn_no;
      txn_no++;
      sb_q.push_back(e);
      txn_valid = 1'b1;
      @(posedge clk);
      if (r) begin
         m_status = 0; m_ie = 0; m_tvec = 0; m_epc = 0; m_cause = 0;
      end else if (take) begin
         m_epc    = p & 32'hFFFF_FFFC;
         m_cause  = 32'h8000_000B;
         m_status = (m_status & ~32'h0000_1888)
                    | (m_status[3] ? 32'h80 : 32'h0) | 32'h0000_1800;
      end else if (wr) begin
         case (a12)
            12'h300: m_status = wd;
            12'h304: m_ie     = wd;
            12'h305: m_tvec   = wd;
            12'h341: m_epc    = wd & 32'hFFFF_FFFC;
            12'h342: m_cause  = wd;
            default: ;
         endcase
      end
      #1;
      txn_valid = 1'b0;
   endtask

   task automatic wr_csr(input logic [31:0] a, input logic [31:0] wd);
      cycle(1'b0, 32'h0, wd, a, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic rd_csr(input logic [31:0] a);
      cycle(1'b0, 32'h0, 32'h0, a, 1'b1, 1'b0, 1'b0);
   endtask

   // Monitor: outputs are combinational, so each live cycle presents one response.
   always @(negedge clk) begin
      if (txn_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: actual=response without expectation required=queued entry");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checks += 2;
            $display("txn %0d rst=%0d addr=%h rd=%0d wr=%0d irq=%0d wd=%h data=%h pc_next=%h",
                     e.id, reset, bus_if.csr_address, bus_if.csr_reg_rd, bus_if.csr_reg_wr,
                     bus_if.interupt, bus_if.write_data, bus_if.data_out_to_reg,
                     bus_if.pc_for_inst_mem);
            if (bus_if.data_out_to_reg !== e.data) begin
               errors++;
               $display("FAIL read_data txn %0d: actual=%h required=%h",
                        e.id, bus_if.data_out_to_reg, e.data);
            end
            if (bus_if.pc_for_inst_mem !== e.pcn) begin
               errors++;
               $display("FAIL pc_for_inst_mem txn %0d: actual=%h required=%h",
                        e.id, bus_if.pc_for_inst_mem, e.pcn);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   logic [31:0] addr_tab [6];

   initial begin
      addr_tab = '{32'h300, 32'h304, 32'h305, 32'h341, 32'h342, 32'h344};
      m_status = 0; m_ie = 0; m_tvec = 0; m_epc = 0; m_cause = 0;
      reset = 1'b1;
      bus_if.pc = 0; bus_if.write_data = 0; bus_if.csr_address = 0;
      bus_if.csr_reg_rd = 0; bus_if.csr_reg_wr = 0; bus_if.interupt = 0;
      @(posedge clk);
      #1;

      // Reset state and read with write disabled
      cycle(1'b1, 32'h40, 32'h0, 32'h300, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 32'h12300ABC, 32'h300, 1'b1, 1'b0, 1'b0);
      rd_csr(32'h300);

      // Read-before-write on each writable CSR, then read back
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 32'h0, 32'h12300001 + i, addr_tab[i], 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) rd_csr(addr_tab[i]);

      // mip is read-only; live MEIP bit; upper address bits ignored
      wr_csr(32'h344, 32'h12300007);
      rd_csr(32'h344);
      cycle(1'b0, 32'h0, 32'h0, 32'hABCD_5344, 1'b1, 1'b0, 1'b1);
      wr_csr(32'h999, 32'hFFFF_FFFF);
      rd_csr(32'h999);

      // Direct-mode trap, held interrupt after trap, state readback
      wr_csr(32'h300, 32'h8); wr_csr(32'h304, 32'h800); wr_csr(32'h305, 32'h100);
      cycle(1'b0, 32'h2004, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 32'h2004, 32'h0, 32'h341, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 32'h2008, 32'h0, 32'h342, 1'b1, 1'b0, 1'b0);
      rd_csr(32'h300);

      // Vectored mode, then interrupt masked by mie
      wr_csr(32'h300, 32'h8); wr_csr(32'h305, 32'h101);
      cycle(1'b0, 32'h2004, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      wr_csr(32'h300, 32'h8); wr_csr(32'h304, 32'h0);
      cycle(1'b0, 32'h2004, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

      // Trap beats a concurrent write; reset overrides a write
      wr_csr(32'h304, 32'h800);
      cycle(1'b0, 32'h3006, 32'hDEAD0000, 32'h305, 1'b0, 1'b1, 1'b1);
      rd_csr(32'h305);
      rd_csr(32'h341);
      cycle(1'b1, 32'h0, 32'h5555_5555, 32'h304, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) rd_csr(addr_tab[i]);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         int sel;
         sel = $urandom_range(0, 7);
         a = (sel < 6) ? addr_tab[sel] : ($urandom & 32'h0000_0FFF);
         if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
         cycle(($urandom_range(0, 49) == 0), $urandom, $urandom, a,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: actual=%0d pending required=0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset sampled on rising clk.
REQ-003: pc  input  32  address of the instruction currently at the CSR/trap point.
REQ-004: write_data  input  32  value written to the addressed CSR.
REQ-005: csr_address  input  32  CSR number; only bits [11:0] decoded, bits [31:12] ignored.
REQ-006: csr_reg_rd  input  1  read enable for data_out_to_reg.
REQ-007: csr_reg_wr  input  1  write enable; write commits on the next rising clk.
REQ-008: interupt  input  1  level-sensitive machine external interrupt request.
REQ-009: data_out_to_reg  output  32  CSR read data to the register file; combinational.
REQ-010: pc_for_inst_mem  output  32  next fetch address, either pass-through pc or trap vector; combinational.

Function
REQ-011: Implemented CSRs are mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342 and mip 0x344; all are 32 bits.
REQ-012: Read: when csr_reg_rd=1, data_out_to_reg = current (pre-write) value of the addressed CSR; unmapped address or csr_reg_rd=0 -> 32'h0.
REQ-013: Write: when csr_reg_wr=1 and no trap is taken, the addressed CSR <= write_data at the rising clk; value is visible on reads from the following cycle.
REQ-014: Writes to unmapped addresses are ignored; mip is read-only and writes to it are ignored.
REQ-015: mepc bits [1:0] are forced to 0 on every update, from a write or a trap.
REQ-016: mip bit 11 (MEIP) = interupt, live and combinational; all other mip bits read 0.
REQ-017: Trap condition: take = interupt & mstatus[3] (MIE) & mie[11] (MEIE), evaluated combinationally each cycle.
REQ-018: On take, the rising clk performs all of:
  - mepc <= {pc[31:2],2'b00}
  - mcause <= 32'h8000_000B
  - mstatus[7] (MPIE) <= mstatus[3]
  - mstatus[3] <= 0
  - mstatus[12:11] (MPP) <= 2'b11
REQ-019: When take=1, pc_for_inst_mem is the trap vector; otherwise pc_for_inst_mem = pc.
REQ-020: Trap vector with mtvec[1:0]==2'b01 (vectored): {mtvec[31:2],2'b00} + 32'd44; any other mtvec[1:0] value: {mtvec[31:2],2'b00} (direct).
REQ-021: A simultaneous csr_reg_wr and take: the trap has priority and the CSR write is dropped in that cycle.
REQ-022: After a take, MIE=0, so a still-asserted interupt takes no further traps until software sets mstatus[3] again.
REQ-023: Simultaneous csr_reg_rd and csr_reg_wr to the same address returns the old value on data_out_to_reg (read-before-write).

Reset
REQ-024: With reset=1 at a rising clk, mstatus, mie, mtvec, mepc and mcause become 32'h0; reset overrides any write or trap in that cycle.
REQ-025: During and after reset, data_out_to_reg is 0 unless a read is enabled; pc_for_inst_mem = pc, since MIE=0 blocks traps.

Verification
REQ-026: Reset, then read 0x300 with rd=1, wr=0 and write_data=0x12300ABC -> data_out_to_reg=0, and mstatus remains 0 afterwards.
REQ-027: Sequential rd+wr writes to 0x300/0x304/0x305/0x341/0x342 with values 0x12300001..0x12300005 -> each read returns the prior value; later reads return 0x12300001, 0x12300002, 0x12300003, 0x12300004, 0x12300005 (mepc bits [1:0] = 0 applied).
REQ-028: Write 0x12300007 to 0x344 with interupt=0 -> the write is ignored and a subsequent read of 0x344 returns 0.
REQ-029: Set mstatus=0x8, mie=0x800, mtvec=0x100, pc=0x2004, then assert interupt -> pc_for_inst_mem=0x100 in the same cycle; after the clk, mepc=0x2004, mcause=0x8000000B, mstatus=0x1880, and pc_for_inst_mem returns to pc.
REQ-030: Same setup with mtvec=0x101 -> pc_for_inst_mem=0x12C; with mie=0 -> no trap and pc_for_inst_mem=pc.
REQ-031: Trap cycle with wr=1 to 0x305 -> mtvec is unchanged; assert reset mid-sequence -> all CSRs return to 0 on the next clk.
